// File: rtl/pc_alu_exec.sv
// Execute-stage slice: word-addressed PC, ALU control decoder and 32-bit ALU.
// The ALU zero flag resolves branch-if-equal into the next PC.
module pc_alu_exec #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              pc_en,
    input  logic              branch,
    input  logic [7:0]        branch_off,
    input  logic [3:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] oper1,
    input  logic [DATA_W-1:0] oper2,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        ctrl_command,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              zero
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_ADDU = 4'b0100;
    localparam logic [3:0] C_SLTU = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_SUBU = 4'b1110;

    localparam int MSB = DATA_W - 1;

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [3:0]        cmd;
    logic [3:0]        funct_cmd;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] res;
    logic              ovf;

    always_comb begin
        funct_cmd = C_ADDU;
        case (funct)
            6'h20:   funct_cmd = C_ADD;
            6'h21:   funct_cmd = C_ADDU;
            6'h22:   funct_cmd = C_SUB;
            6'h23:   funct_cmd = C_SUBU;
            6'h24:   funct_cmd = C_AND;
            6'h25:   funct_cmd = C_OR;
            6'h26:   funct_cmd = C_XOR;
            6'h27:   funct_cmd = C_NOR;
            6'h2A:   funct_cmd = C_SLT;
            6'h2B:   funct_cmd = C_SLTU;
            6'h00:   funct_cmd = C_SLL;
            6'h02:   funct_cmd = C_SRL;
            6'h03:   funct_cmd = C_SRA;
            default: funct_cmd = C_ADDU;
        endcase
    end

    always_comb begin
        cmd = C_ADD;
        case (alu_op)
            4'b0000: cmd = C_ADD;
            4'b0001: cmd = C_SUB;
            4'b0010: cmd = funct_cmd;
            4'b0011: cmd = C_AND;
            4'b0100: cmd = C_OR;
            4'b0101: cmd = C_SLT;
            4'b0110: cmd = C_XOR;
            default: cmd = C_ADD;
        endcase
    end

    assign sum  = oper1 + oper2;
    assign diff = oper1 - oper2;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (cmd)
            C_AND:  res = oper1 & oper2;
            C_OR:   res = oper1 | oper2;
            C_XOR:  res = oper1 ^ oper2;
            C_NOR:  res = ~(oper1 | oper2);
            C_ADDU: res = sum;
            C_SUBU: res = diff;
            C_ADD: begin
                res = sum;
                ovf = (oper1[MSB] == oper2[MSB]) && (sum[MSB] != oper1[MSB]);
            end
            C_SUB: begin
                res = diff;
                ovf = (oper1[MSB] != oper2[MSB]) && (diff[MSB] != oper1[MSB]);
            end
            C_SLT:  res = DATA_W'($signed(oper1) < $signed(oper2));
            C_SLTU: res = DATA_W'(oper1 < oper2);
            C_SLL:  res = oper2 << shamt;
            C_SRL:  res = oper2 >> shamt;
            C_SRA:  res = $unsigned($signed(oper2) >>> shamt);
            default: res = '0;
        endcase
    end

    // Branch target is relative to the already-incremented PC.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            if (branch && (res == '0)) begin
                pc_d = pc_q + PC_W'(1) + PC_W'($signed(branch_off));
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc           = pc_q;
    assign ctrl_command = cmd;
    assign result       = res;
    assign overflow     = ovf;
    assign zero         = (res == '0);

endmodule

// File: tb/tb_pc_alu_exec.sv
// Directed self-checking bench for pc_alu_exec.
// Checks PC reset/increment/wrap/branch/stall and ALU decode/results.
module tb_pc_alu_exec;

    logic        clk;
    logic        clr;
    logic        pc_en;
    logic        branch;
    logic [7:0]  branch_off;
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] oper1;
    logic [31:0] oper2;
    logic [7:0]  pc;
    logic [3:0]  ctrl_command;
    logic [31:0] result;
    logic        overflow;
    logic        zero;

    int checks;
    int failures;

    pc_alu_exec dut (
        .clk          (clk),
        .clr          (clr),
        .pc_en        (pc_en),
        .branch       (branch),
        .branch_off   (branch_off),
        .alu_op       (alu_op),
        .funct        (funct),
        .shamt        (shamt),
        .oper1        (oper1),
        .oper2        (oper2),
        .pc           (pc),
        .ctrl_command (ctrl_command),
        .result       (result),
        .overflow     (overflow),
        .zero         (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] a,
                       input logic [31:0] b);
        alu_op = op;
        funct  = fn;
        shamt  = sh;
        oper1  = a;
        oper2  = b;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        clr        = 1'b0;
        pc_en      = 1'b0;
        branch     = 1'b0;
        branch_off = 8'h00;
        alu_op     = 4'b0000;
        funct      = 6'h00;
        shamt      = 5'd0;
        oper1      = 32'd0;
        oper2      = 32'd1;

        edge1();
        chk("reset_pc", 32'(pc), 32'd0);
        edge1();
        clr   = 1'b1;
        pc_en = 1'b1;
        edge1();
        chk("inc_1", 32'(pc), 32'd1);
        edge1();
        chk("inc_2", 32'(pc), 32'd2);
        edge1();
        chk("inc_3", 32'(pc), 32'd3);

        #2;
        clr = 1'b0;
        #1;
        chk("async_clr", 32'(pc), 32'd0);
        edge1();
        chk("clr_hold", 32'(pc), 32'd0);
        clr = 1'b1;

        for (int i = 0; i < 255; i++) edge1();
        chk("pc_255", 32'(pc), 32'd255);
        edge1();
        chk("pc_wrap", 32'(pc), 32'd0);
        pc_en = 1'b0;

        alu(4'b0010, 6'h22, 5'd0, 32'd5, 32'd7);
        chk("sub_cmd", 32'(ctrl_command), 32'h6);
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_zero", 32'(zero), 32'd0);
        chk("sub_ovf", 32'(overflow), 32'd0);

        alu(4'b0010, 6'h27, 5'd0, 32'd0, 32'd0);
        chk("nor_cmd", 32'(ctrl_command), 32'hC);
        chk("nor_res", result, 32'hFFFF_FFFF);

        alu(4'b0000, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add_res", result, 32'h8000_0000);
        chk("add_ovf", 32'(overflow), 32'd1);

        alu(4'b0010, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1);
        chk("addu_cmd", 32'(ctrl_command), 32'h4);
        chk("addu_res", result, 32'h8000_0000);
        chk("addu_ovf", 32'(overflow), 32'd0);

        alu(4'b0001, 6'h00, 5'd0, 32'h8000_0000, 32'd1);
        chk("subov_res", result, 32'h7FFF_FFFF);
        chk("subov_ovf", 32'(overflow), 32'd1);

        alu(4'b0101, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1);
        chk("slt_cmd", 32'(ctrl_command), 32'h7);
        chk("slt_res", result, 32'd1);

        alu(4'b0010, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_res", result, 32'd0);
        chk("sltu_zero", 32'(zero), 32'd1);

        alu(4'b0010, 6'h03, 5'd4, 32'd0, 32'h8000_0000);
        chk("sra_res", result, 32'hF800_0000);

        alu(4'b0010, 6'h02, 5'd4, 32'd0, 32'h8000_0000);
        chk("srl_res", result, 32'h0800_0000);

        alu(4'b0010, 6'h00, 5'd31, 32'd0, 32'd1);
        chk("sll_res", result, 32'h8000_0000);

        alu(4'b0010, 6'h26, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("xor_res", result, 32'h0FF0_0FF0);

        alu(4'b0100, 6'h00, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
        chk("or_res", result, 32'hF0F0_0F0F);

        alu(4'b0011, 6'h00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and_res", result, 32'hF000_F000);

        alu(4'b1111, 6'h00, 5'd0, 32'd2, 32'd3);
        chk("dflt_op_cmd", 32'(ctrl_command), 32'h2);
        chk("dflt_op_res", result, 32'd5);

        alu(4'b0010, 6'h3F, 5'd0, 32'd2, 32'd3);
        chk("dflt_fn_cmd", 32'(ctrl_command), 32'h4);

        alu(4'b0000, 6'h00, 5'd0, 32'd0, 32'd1);
        pc_en = 1'b1;
        for (int i = 0; i < 10; i++) edge1();
        chk("pc_10", 32'(pc), 32'd10);

        branch     = 1'b1;
        branch_off = 8'hFC;
        alu(4'b0001, 6'h00, 5'd0, 32'd42, 32'd42);
        chk("beq_zero", 32'(zero), 32'd1);
        edge1();
        chk("beq_taken", 32'(pc), 32'd7);

        branch = 1'b0;
        for (int i = 0; i < 3; i++) edge1();
        chk("pc_10b", 32'(pc), 32'd10);

        branch = 1'b1;
        alu(4'b0001, 6'h00, 5'd0, 32'd42, 32'd43);
        chk("bne_zero", 32'(zero), 32'd0);
        edge1();
        chk("beq_not_taken", 32'(pc), 32'd11);

        pc_en = 1'b0;
        alu(4'b0001, 6'h00, 5'd0, 32'd42, 32'd42);
        edge1();
        chk("stall", 32'(pc), 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_alu_exec.md
Name: pc_alu_exec

Overview:
- Execute-stage slice of the single-cycle MIPS core.
- Contains the 8-bit word-addressed program counter (PC), the ALU control decoder (ALUOp + funct -> 4-bit command) and the 32-bit ALU.
- PC feeds the instruction memory. The ALU consumes register-file read data, and its zero flag drives branch resolution back into the PC.

Parameters:
- PC_W, 8, program counter width (word address into instruction memory)
- DATA_W, 32, ALU operand/result width

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  reset; one clock; asynchronous, active-low
- pc_en  input  1  PC update enable (0 = hold/stall)
- branch  input  1  branch-if-equal from main control
- branch_off  input  8  signed word offset (instruction imm[7:0])
- alu_op  input  4  ALUOp from main control
- funct  input  6  instruction[5:0]
- shamt  input  5  instruction[10:6]
- oper1  input  32  rs data
- oper2  input  32  rt data or immediate (selected upstream)
- pc  output  8  current PC
- ctrl_command  output  4  decoded ALU command
- result  output  32  ALU result
- overflow  output  1  signed overflow
- zero  output  1  result == 0

Behaviour:
- PC register:
  - clr low: pc = 0 immediately (asynchronous), held while low.
  - Rising clk with pc_en=0: pc holds.
  - Rising clk with pc_en=1:
    - If branch=1 and zero=1: pc <= pc + 1 + branch_off. The offset is two's complement; the sum is mod 256.
    - Otherwise pc <= pc + 1. 255 wraps to 0.
  - zero is sampled from the current-cycle combinational ALU result.
- ALU control (combinational) maps alu_op to ctrl_command:
  - 0000 -> ADD
  - 0001 -> SUB
  - 0010 -> decode funct
  - 0011 -> AND
  - 0100 -> OR
  - 0101 -> SLT
  - 0110 -> XOR
  - all other alu_op values -> ADD
- funct decode (used when alu_op=0010):
  - 0x20 ADD; 0x21 ADDU; 0x22 SUB; 0x23 SUBU
  - 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR
  - 0x2A SLT; 0x2B SLTU
  - 0x00 SLL; 0x02 SRL; 0x03 SRA
  - unlisted funct -> ADDU
- Command encodings:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - ADDU 0100, SLTU 0101, SUB 0110, SLT 0111
  - SLL 1000, SRL 1001, SRA 1010
  - NOR 1100, SUBU 1110
  - Undefined codes: result = 0.
- ALU (combinational, no latency):
  - Add/subtract results wrap mod 2^32.
  - SLT: signed compare, result = 1 or 0 (zero-extended). SLTU: unsigned compare.
  - Shifts operate on oper2 by shamt. SRA replicates bit 31.
  - overflow is asserted only for ADD/SUB on signed overflow:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operand signs differ and the result sign differs from oper1.
  - overflow = 0 for every other command, including ADDU/SUBU. The result is still driven when overflow=1.
  - zero = (result == 0) for every command.
- Reset has no effect on the combinational paths.
- Outputs during reset: pc=0. result, overflow, zero and ctrl_command follow their inputs.

Test Plan:
- Reset and increment:
  - Assert clr=0 mid-cycle -> pc=0 without waiting for a clock edge.
  - Release clr with pc_en=1 -> pc = 1, 2, 3 on successive edges.
  - Preload to 255 -> next pc = 0.
- R-type decode:
  - alu_op=0010, funct=0x22, oper1=5, oper2=7 -> ctrl_command=0110, result=0xFFFFFFFE, zero=0.
  - funct=0x27 with oper1=oper2=0 -> result=0xFFFFFFFF.
- Overflow:
  - ADD 0x7FFFFFFF + 1 -> result=0x80000000, overflow=1.
  - ADDU with the same operands -> overflow=0.
  - SUB 0x80000000 - 1 -> overflow=1.
- Compares and shifts:
  - SLT of -1 vs 1 -> 1; SLTU of the same operands -> 0.
  - SRA of 0x80000000 by shamt=4 -> 0xF8000000.
  - SLL of 1 by shamt=31 -> 0x80000000.
- Branch:
  - pc=10, alu_op=0001, oper1=oper2=42, branch=1, branch_off=0xFC (-4) -> zero=1, next pc=7.
  - Same with oper2=43 -> next pc=11.
- Stall:
  - pc_en=0 with branch taken -> pc unchanged for the cycle.
